fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 206 ++++++++++++++++++++
 tb/tb_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction prefetch stage in front of the program ROM.
// Issues sequential word addresses on the shared read bus, tracks each
// fetch through a two-stage in-flight pipeline that matches the ROM's
// one-cycle registered latency, and buffers the returned words (tagged
// with their address) in a small FIFO for the decoder.
//
// Ports:
//   read_clk      bus read clock, all state changes on its rising edge
//   reset         asynchronous, active-high
//   bus_grant     this unit may drive the read bus
//   read_addr     registered fetch address for the read bus
//   read_addr_en  registered tri-state enable for read_addr
//   data_in       data bus as seen by this unit
//   halt          stop issuing new fetches
//   jump_valid    redirect request (flushes FIFO and in-flight fetches)
//   jump_addr     redirect target
//   instr_valid   FIFO head valid
//   instr_data    FIFO head word
//   instr_addr    address of the FIFO head word
//   instr_ready   decoder accepts the head this edge
//   idle          FIFO empty and nothing in flight
module fetch_unit #(
  parameter int                WORD_W       = 16,
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000,
  parameter int                DEPTH        = 4
) (
  input  logic              read_clk,
  input  logic              reset,
  input  logic              bus_grant,
  output logic [ADDR_W-1:0] read_addr,
  output logic              read_addr_en,
  input  logic [WORD_W-1:0] data_in,
  input  logic              halt,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              instr_valid,
  output logic [WORD_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_ready,
  output logic              idle
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] pc_r;

  // In-flight pipeline: stage 1 = address on the bus, stage 2 = ROM output pending
  logic              s1_valid_r;
  logic [ADDR_W-1:0] s1_addr_r;
  logic              s2_valid_r;
  logic [ADDR_W-1:0] s2_addr_r;

  logic [WORD_W-1:0] mem_data_r [DEPTH];
  logic [ADDR_W-1:0] mem_addr_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;

  logic [OCC_W-1:0]  occupancy_s;
  logic              issue_s;
  logic              push_s;
  logic              pop_s;
  logic              s1_valid_nxt_s;
  logic              s2_valid_nxt_s;
  logic [PTR_W-1:0]  wr_ptr_nxt_s;
  logic [PTR_W-1:0]  rd_ptr_nxt_s;
  logic [CNT_W-1:0]  count_nxt_s;
  logic [WORD_W-1:0] head_data_nxt_s;
  logic [ADDR_W-1:0] head_addr_nxt_s;

  // Credit check counts buffered plus in-flight words so a push never meets a full FIFO
  always_comb begin
    occupancy_s    = OCC_W'(count_r) + OCC_W'(s1_valid_r) + OCC_W'(s2_valid_r);
    issue_s        = (state_r == ST_RUN) && bus_grant && !jump_valid &&
                     (occupancy_s < OCC_W'(DEPTH));
    push_s         = s2_valid_r && !jump_valid;
    pop_s          = instr_valid && instr_ready && !jump_valid;
    s1_valid_nxt_s = issue_s;
    s2_valid_nxt_s = s1_valid_r && !jump_valid;
  end

  // Next FIFO pointers/count; a jump empties the FIFO and discards any pop
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    if (jump_valid) begin
      wr_ptr_nxt_s = {PTR_W{1'b0}};
      rd_ptr_nxt_s = {PTR_W{1'b0}};
      count_nxt_s  = {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CNT_W'(1);
        2'b01:   count_nxt_s = count_r - CNT_W'(1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Next head word; bypass the incoming word when it lands in the head slot
  always_comb begin
    if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
      head_data_nxt_s = data_in;
      head_addr_nxt_s = s2_addr_r;
    end else begin
      head_data_nxt_s = mem_data_r[rd_ptr_nxt_s];
      head_addr_nxt_s = mem_addr_r[rd_ptr_nxt_s];
    end
  end

  // Control FSM with program counter and registered bus drive
  always_ff @(posedge read_clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      pc_r         <= RESET_VECTOR;
      read_addr    <= {ADDR_W{1'b0}};
      read_addr_en <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE:   state_r <= ST_RUN;
        ST_RUN:    state_r <= halt ? ST_HALTED : ST_RUN;
        ST_HALTED: state_r <= halt ? ST_HALTED : ST_RUN;
        default:   state_r <= ST_IDLE;
      endcase
      if (jump_valid) begin
        pc_r         <= jump_addr;
        read_addr_en <= 1'b0;
      end else if (issue_s) begin
        read_addr    <= pc_r;
        read_addr_en <= 1'b1;
        pc_r         <= pc_r + ADDR_W'(1);
      end else begin
        read_addr_en <= 1'b0;
      end
    end
  end

  // In-flight stages follow the ROM's one-cycle registered read latency
  always_ff @(posedge read_clk or posedge reset) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_addr_r  <= {ADDR_W{1'b0}};
      s2_valid_r <= 1'b0;
      s2_addr_r  <= {ADDR_W{1'b0}};
    end else begin
      s1_valid_r <= s1_valid_nxt_s;
      if (issue_s) begin
        s1_addr_r <= pc_r;
      end
      s2_valid_r <= s2_valid_nxt_s;
      s2_addr_r  <= s1_addr_r;
    end
  end

  // FIFO storage plus registered head and idle outputs
  always_ff @(posedge read_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_r[i] <= {WORD_W{1'b0}};
        mem_addr_r[i] <= {ADDR_W{1'b0}};
      end
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      instr_valid <= 1'b0;
      instr_data  <= {WORD_W{1'b0}};
      instr_addr  <= {ADDR_W{1'b0}};
      idle        <= 1'b1;
    end else begin
      if (push_s) begin
        mem_data_r[wr_ptr_r] <= data_in;
        mem_addr_r[wr_ptr_r] <= s2_addr_r;
      end
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      instr_valid <= (count_nxt_s != {CNT_W{1'b0}});
      if (count_nxt_s != {CNT_W{1'b0}}) begin
        instr_data <= head_data_nxt_s;
        instr_addr <= head_addr_nxt_s;
      end
      idle <= (count_nxt_s == {CNT_W{1'b0}}) && !s1_valid_nxt_s && !s2_valid_nxt_s;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a transaction-level model (queues of buffered words
// and of outstanding fetches with their due cycle) is compared against the
// DUT every cycle, plus hand-computed literal checks. A second instance with
// RESET_VECTOR = 16'hFFFE covers address wrap-around.
module tb_fetch_unit;
  localparam int DEPTH = 4;

  logic        read_clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_grant = 1'b1;
  logic        halt = 1'b0;
  logic        jump_valid = 1'b0;
  logic [15:0] jump_addr = 16'h0000;
  logic        instr_ready = 1'b1;

  logic [15:0] read_addr, instr_data, instr_addr;
  logic        read_addr_en, instr_valid, idle;
  logic [15:0] rom_q = 16'h0000;

  logic [15:0] read_addr2, instr_data2, instr_addr2;
  logic        read_addr_en2, instr_valid2, idle2;
  logic [15:0] rom2_q = 16'h0000;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.WORD_W(16), .ADDR_W(16), .RESET_VECTOR(16'h0000), .DEPTH(DEPTH)) dut (
    .read_clk(read_clk), .reset(reset), .bus_grant(bus_grant),
    .read_addr(read_addr), .read_addr_en(read_addr_en), .data_in(rom_q),
    .halt(halt), .jump_valid(jump_valid), .jump_addr(jump_addr),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_addr(instr_addr),
    .instr_ready(instr_ready), .idle(idle));

  fetch_unit #(.WORD_W(16), .ADDR_W(16), .RESET_VECTOR(16'hFFFE), .DEPTH(DEPTH)) dut2 (
    .read_clk(read_clk), .reset(reset), .bus_grant(1'b1),
    .read_addr(read_addr2), .read_addr_en(read_addr_en2), .data_in(rom2_q),
    .halt(1'b0), .jump_valid(1'b0), .jump_addr(16'h0000),
    .instr_valid(instr_valid2), .instr_data(instr_data2), .instr_addr(instr_addr2),
    .instr_ready(1'b1), .idle(idle2));

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1111;
      16'h0001: return 16'h2222;
      16'h0002: return 16'h3333;
      16'h0003: return 16'h4444;
      default:  return a ^ 16'hA5A5;
    endcase
  endfunction

  always #5 read_clk = ~read_clk;

  // ROMs: sample the bus address and register the word on the same edge
  always @(posedge read_clk) begin
    rom_q  <= rom_word(read_addr);
    rom2_q <= rom_word(read_addr2);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic [15:0] addr; logic [15:0] data; } word_t;
  typedef struct packed { logic [15:0] addr; logic [31:0] due; } fetch_t;

  word_t       m_fifo[$];
  fetch_t      m_fl[$];
  logic [31:0] cyc = 32'd0;
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_ra = 16'h0000;
  logic        m_en = 1'b0;
  int          m_mode = 0;   // 0 = just out of reset, 1 = running, 2 = halted

  task automatic model_reset();
    m_fifo.delete();
    m_fl.delete();
    m_pc   = 16'h0000;
    m_ra   = 16'h0000;
    m_en   = 1'b0;
    m_mode = 0;
  endtask

  task automatic model_step();
    bit     do_pop, do_issue;
    word_t  w;
    fetch_t f;
    cyc++;
    do_pop   = (m_fifo.size() > 0) && instr_ready;
    do_issue = (m_mode == 1) && bus_grant && !jump_valid &&
               (m_fifo.size() + m_fl.size() < DEPTH);
    if (jump_valid) begin
      m_fifo.delete();
      m_fl.delete();
      m_pc = jump_addr;
      m_en = 1'b0;
    end else begin
      if (do_pop) void'(m_fifo.pop_front());
      while (m_fl.size() > 0 && m_fl[0].due == cyc) begin
        w.addr = m_fl[0].addr;
        w.data = rom_word(m_fl[0].addr);
        m_fifo.push_back(w);
        void'(m_fl.pop_front());
      end
      if (do_issue) begin
        f.addr = m_pc;
        f.due  = cyc + 32'd2;
        m_fl.push_back(f);
        m_ra = m_pc;
        m_en = 1'b1;
        m_pc = m_pc + 16'h0001;
      end else begin
        m_en = 1'b0;
      end
    end
    if (m_mode == 0) m_mode = 1;
    else m_mode = halt ? 2 : 1;
  endtask

  // Single compare process: advance model on the edge, check on the falling edge
  initial begin
    forever begin
      @(posedge read_clk or posedge reset);
      if (reset) model_reset();
      else model_step();
      @(negedge read_clk);
      if (reset) model_reset();
      check("m_read_addr_en", {31'd0, read_addr_en}, {31'd0, m_en});
      check("m_read_addr", {16'd0, read_addr}, {16'd0, m_ra});
      check("m_instr_valid", {31'd0, instr_valid}, {31'd0, m_fifo.size() > 0});
      if (m_fifo.size() > 0) begin
        check("m_instr_data", {16'd0, instr_data}, {16'd0, m_fifo[0].data});
        check("m_instr_addr", {16'd0, instr_addr}, {16'd0, m_fifo[0].addr});
      end
      check("m_idle", {31'd0, idle}, {31'd0, (m_fifo.size() == 0) && (m_fl.size() == 0)});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge read_clk);
    @(negedge read_clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bit          seen;
    logic [15:0] first_addr;
    repeat (2) @(negedge read_clk);
    check("rst_read_addr", {16'd0, read_addr}, 32'h0000_0000);
    check("rst_read_addr_en", {31'd0, read_addr_en}, 32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr_data", {16'd0, instr_data}, 32'h0000_0000);
    check("rst_instr_addr", {16'd0, instr_addr}, 32'h0000_0000);
    check("rst_idle", {31'd0, idle}, 32'd1);

    // Streaming from reset with the decoder always ready
    reset = 1'b0;
    step(2);
    check("first_issue_addr", {16'd0, read_addr}, 32'h0000_0000);
    check("first_issue_en", {31'd0, read_addr_en}, 32'd1);
    step(1);
    check("second_issue_addr", {16'd0, read_addr}, 32'h0000_0001);
    check("valid_not_yet", {31'd0, instr_valid}, 32'd0);
    step(1);
    check("w0_valid", {31'd0, instr_valid}, 32'd1);
    check("w0_data", {16'd0, instr_data}, 32'h0000_1111);
    check("w0_addr", {16'd0, instr_addr}, 32'h0000_0000);
    check("wrap_w0_addr", {16'd0, instr_addr2}, 32'h0000_FFFE);
    check("wrap_w0_data", {16'd0, instr_data2}, 32'h0000_5A5B);
    step(1);
    check("w1_data", {16'd0, instr_data}, 32'h0000_2222);
    check("w1_addr", {16'd0, instr_addr}, 32'h0000_0001);
    check("wrap_w1_addr", {16'd0, instr_addr2}, 32'h0000_FFFF);
    step(1);
    check("w2_data", {16'd0, instr_data}, 32'h0000_3333);
    check("wrap_w2_addr", {16'd0, instr_addr2}, 32'h0000_0000);
    step(1);
    check("w3_data", {16'd0, instr_data}, 32'h0000_4444);
    check("w3_addr", {16'd0, instr_addr}, 32'h0000_0003);
    check("wrap_w3_addr", {16'd0, instr_addr2}, 32'h0000_0001);
    step(4);

    // Decoder stalled from reset: credit limit of DEPTH outstanding words
    reset = 1'b1;
    instr_ready = 1'b0;
    step(2);
    reset = 1'b0;
    step(12);
    check("stall_valid", {31'd0, instr_valid}, 32'd1);
    check("stall_head_addr", {16'd0, instr_addr}, 32'h0000_0000);
    check("stall_head_data", {16'd0, instr_data}, 32'h0000_1111);
    check("stall_en_low", {31'd0, read_addr_en}, 32'd0);
    check("stall_last_addr", {16'd0, read_addr}, 32'h0000_0003);
    check("stall_not_idle", {31'd0, idle}, 32'd0);
    instr_ready = 1'b1;
    step(1);
    check("drain_head_addr", {16'd0, instr_addr}, 32'h0000_0001);
    check("drain_head_data", {16'd0, instr_data}, 32'h0000_2222);
    step(10);

    // Jump with two words buffered and two in flight
    reset = 1'b1;
    instr_ready = 1'b0;
    step(2);
    reset = 1'b0;
    step(5);
    jump_valid = 1'b1;
    jump_addr = 16'h0100;
    step(1);
    check("jump_flush_valid", {31'd0, instr_valid}, 32'd0);
    check("jump_flush_en", {31'd0, read_addr_en}, 32'd0);
    jump_valid = 1'b0;
    instr_ready = 1'b1;
    step(1);
    check("jump_issue_addr", {16'd0, read_addr}, 32'h0000_0100);
    step(2);
    check("jump_word_valid", {31'd0, instr_valid}, 32'd1);
    check("jump_word_addr", {16'd0, instr_addr}, 32'h0000_0100);
    check("jump_word_data", {16'd0, instr_data}, 32'h0000_A4A5);
    step(3);
    // Back-to-back jumps: the last one wins
    jump_valid = 1'b1;
    jump_addr = 16'h0200;
    step(1);
    jump_addr = 16'h0300;
    step(1);
    jump_valid = 1'b0;
    step(1);
    check("jump2_issue_addr", {16'd0, read_addr}, 32'h0000_0300);
    step(2);
    check("jump2_word_addr", {16'd0, instr_addr}, 32'h0000_0300);
    check("jump2_word_data", {16'd0, instr_data}, 32'h0000_A6A5);
    step(6);

    // Halt for five cycles mid-stream
    halt = 1'b1;
    step(5);
    check("halt_idle", {31'd0, idle}, 32'd1);
    check("halt_en_low", {31'd0, read_addr_en}, 32'd0);
    check("halt_valid_low", {31'd0, instr_valid}, 32'd0);
    halt = 1'b0;
    step(8);

    // Grant toggling with a reset pulse in the middle of a transfer
    for (int i = 0; i < 8; i++) begin
      bus_grant = ~bus_grant;
      step(1);
    end
    @(posedge read_clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_en", {31'd0, read_addr_en}, 32'd0);
    check("async_rst_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge read_clk);
    reset = 1'b0;
    seen = 1'b0;
    first_addr = 16'hDEAD;
    for (int i = 0; i < 12; i++) begin
      bus_grant = ~bus_grant;
      step(1);
      if (!seen && read_addr_en) begin
        seen = 1'b1;
        first_addr = read_addr;
      end
    end
    check("restart_seen", {31'd0, seen}, 32'd1);
    check("restart_addr", {16'd0, first_addr}, 32'h0000_0000);
    bus_grant = 1'b1;
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
